// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder sequencer that time-multiplexes one external 4-bit CLA slice, one nibble per clock, LSB first.
// Latency is NIB+1 cycles from start to done. Start is ignored while busy. Define NIBBLE_SERIAL_SUB_EN to add a 'sub' port for A-B.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_s,
    input  logic             slice_c3,
    input  logic             slice_c4
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
`ifdef NIBBLE_SERIAL_SUB_EN
                    // Two's-complement subtract: invert B and force the carry-in.
                    if (sub) begin
                        b_d     = ~in_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                slice_a   = a_q[{idx_q, 2'b00} +: 4];
                slice_b   = b_q[{idx_q, 2'b00} +: 4];
                slice_cin = carry_q;
                sum_d[{idx_q, 2'b00} +: 4] = slice_s;
                carry_d   = slice_c4;
                // idx saturates on the last nibble, so it never wraps.
                if (idx_q == LAST) begin
                    cout_d  = slice_c4;
                    ovf_d   = slice_c3 ^ slice_c4;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: models the external CLA slice and checks results against plain arithmetic.
module tb_nibble_serial_add_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;
    logic [3:0]   slice_a, slice_b, slice_s;
    logic         slice_cin, slice_c3, slice_c4;
    logic [3:0]   low3;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] last_sum;

    always #5 clk = ~clk;

    // External 4-bit slice: plain arithmetic, C3 is the carry into bit 3.
    assign {slice_c4, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};
    assign low3     = {1'b0, slice_a[2:0]} + {1'b0, slice_b[2:0]} + {3'h0, slice_cin};
    assign slice_c3 = low3[3];

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_s   (slice_s),
        .slice_c3  (slice_c3),
        .slice_c4  (slice_c4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        in_cin = 1'($urandom_range(0, 1));
`ifdef NIBBLE_SERIAL_SUB_EN
        sub    = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        int           sv;
        logic         exp_ovf;
        logic [31:0]  m, cj;
        logic [3:0]   na, nb;
        bb      = s ? ~b : b;
        cc      = s ? 1'b1 : cin;
        full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        sv      = int'($signed(a)) + int'($signed(bb)) + int'(cc);
        exp_ovf = (sv > 32767) || (sv < -32768);

        @(negedge clk);
        start = 1'b1; in_a = a; in_b = b; in_cin = cin;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = s;
`endif
        @(negedge clk);
        for (int j = 0; j < NIB; j++) begin
            if (j == 0) check("sum_hold_prev", 32'(sum), 32'(last_sum));
            m  = (32'd1 << (4 * j)) - 32'd1;
            cj = (((32'(a) & m) + (32'(bb) & m) + 32'(cc)) >> (4 * j)) & 32'd1;
            na = 4'((a >> (4 * j)) & 16'hF);
            nb = 4'((bb >> (4 * j)) & 16'hF);
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("slice_a", 32'(slice_a), 32'(na));
            check("slice_b", 32'(slice_b), 32'(nb));
            check("slice_cin", 32'(slice_cin), cj);
            // Anything presented while busy must be ignored.
            start = 1'($urandom_range(0, 1));
            scramble_inputs();
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("cout", 32'(cout), 32'(full[W]));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("slice_a_idle", 32'(slice_a), 32'd0);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("sum_held", 32'(sum), 32'(full[W-1:0]));
        last_sum = full[W-1:0];
    endtask

    task automatic reset_mid_run();
        int n_done;
        @(negedge clk);
        start = 1'b1; in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_slice_a", 32'(slice_a), 32'd0);
        check("rst_slice_cin", 32'(slice_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_abort", 32'(n_done), 32'd0);
        last_sum = '0;
    endtask

    task automatic handshake();
        int n_done, first_at, second_at;
        n_done = 0; first_at = -1; second_at = -1;
        @(negedge clk);
        start = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) first_at = i;
                if (n_done == 2) second_at = i;
                check("hs_sum", 32'(sum), 32'h2);
            end
            if ((i >= 1 && i <= 4) || (i >= 7 && i <= 10)) scramble_inputs();
            if (i == 5) begin
                in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
                sub = 1'b0;
`endif
            end
            if (i == 10) start = 1'b0;
        end
        check("hs_done_count", 32'(n_done), 32'd2);
        check("hs_first_done", 32'(first_at), 32'd5);
        check("hs_second_done", 32'(second_at), 32'd11);
        last_sum = 16'h0002;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        last_sum = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_slice_b", 32'(slice_b), 32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        reset_mid_run();
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        handshake();
`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1);
`endif
        for (int t = 0; t < 40; t++) begin
            logic s;
`ifdef NIBBLE_SERIAL_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 4-bit carry-lookahead adder slice, one nibble per clock, LSB nibble first.
- Owns operand and result registers, the inter-nibble carry register and a start/busy/done handshake.
- Sits between a requesting datapath and a single shared 4-bit CLA slice instance.
- The slice is combinational with a carry-in. The controller presents operands and carry-in, then captures sum and carries on the next clock edge.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (NIB = WIDTH/4 nibbles).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- in_a  input  WIDTH  operand A, captured on accepted start.
- in_b  input  WIDTH  operand B, captured on accepted start.
- in_cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB nibble.
- ovf  output  1  signed overflow = slice_c3 XOR slice_c4 on the final nibble.
- slice_a  output  4  nibble of A presented to the slice.
- slice_b  output  4  nibble of B presented to the slice.
- slice_cin  output  1  carry-in presented to the slice.
- slice_s  input  4  slice sum S3..S0.
- slice_c3  input  1  slice carry into bit 3 (C3).
- slice_c4  input  1  slice carry out (C4).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; sum=0; cout=0; ovf=0; carry_reg=0; idx=0; operand registers=0.
- Slice outputs slice_a, slice_b and slice_cin are 0 whenever state != RUN.
- Reset asserted mid-operation aborts immediately. Outputs go to their reset values and no done pulse is produced.
- IDLE:
  - start=1 latches in_a, in_b and in_cin into a_reg, b_reg and carry_reg.
  - It clears idx to 0 and moves to RUN.
  - sum, cout and ovf keep the previous result until the first RUN capture.
- RUN, each cycle:
  - Drive slice_a=a_reg[4*idx+3:4*idx], slice_b=b_reg[4*idx+3:4*idx], slice_cin=carry_reg.
  - On the rising edge: sum[4*idx+3:4*idx]<=slice_s; carry_reg<=slice_c4; idx<=idx+1.
  - When idx==NIB-1, also capture cout<=slice_c4 and ovf<=slice_c3^slice_c4, then move to DONE.
  - idx is ceil(log2(NIB)) bits wide, minimum 1, and never wraps past NIB-1.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - sum, cout and ovf hold until a later RUN overwrites them.
- Latency: start accepted at edge k gives done=1 during the cycle after edge k+NIB, i.e. NIB+1 cycles from start to done.
- Throughput: one operation per NIB+2 cycles; back-to-back start on the cycle after done is accepted.
- start while busy=1 is ignored and not queued.
- Changes on in_a, in_b or in_cin after acceptance have no effect on the running operation.
- WIDTH=4 (NIB=1): a single RUN cycle, then DONE.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1: b_reg<=~in_b, carry_reg<=1 (in_cin ignored), giving A-B.
  - cout=1 means no borrow; ovf flags signed subtraction overflow.
  - When sub=0: behaviour is identical to the addition mode.
- Not defined: no sub port; addition only.

Test Plan:
- Reset mid-RUN: WIDTH=16, start A=16'h1234 B=16'h1111 cin=0, assert rst_n=0 after 2 RUN cycles -> immediately busy=0, done=0, sum=0, cout=0, ovf=0, slice_a=0; no done pulse after release.
- Basic add: WIDTH=16, A=16'h1234, B=16'h1111, cin=0 -> done in cycle 5 after start; sum=16'h2345, cout=0, ovf=0; slice_a sequence 4,3,2,1.
- Full ripple: A=16'hFFFF, B=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0; slice_cin=1 in all 4 RUN cycles.
- Signed overflow: A=16'h7FFF, B=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- Handshake: start held high for 10 cycles with A=16'h0001, B=16'h0001 -> two operations, done pulses 6 cycles apart (start accepted in IDLE, 4 RUN, 1 DONE); operand change during RUN ignored; each result sum=16'h0002.
- NIBBLE_SERIAL_SUB_EN: sub=1, A=16'h0005, B=16'h0007 -> sum=16'hFFFE, cout=0 (borrow), ovf=0; sub=1, A=16'h8000, B=16'h0001 -> sum=16'h7FFF, ovf=1.
